linescanner_capture_controller: RTL and testbench

//  Parametrised line-scan sensor controller: drives exposure/reset timing (rst_cvc, rst_cds, sample),

---
 rtl/linescanner_pkg.sv | 27 ++
 rtl/linescanner_phase_timer.sv | 31 +++
 rtl/linescanner_capture_controller.sv | 238 +++++++++++++++++++++++
 tb/tb_linescanner_capture_controller.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/linescanner_pkg.sv
// Shared types for the line-scan capture controller: exposure and load
// state encodings plus the default timing-counter type.
package linescanner_pkg;

    localparam int DEFAULT_CNT_WIDTH = 8;

    typedef logic [DEFAULT_CNT_WIDTH-1:0] timing_cnt_t;

    typedef enum logic [2:0] {
        EXP_IDLE,
        EXP_CVC_LOW,
        EXP_CDS_LOW,
        EXP_WAIT_ADC,
        EXP_SAMPLE_HI,
        EXP_HOLD,
        EXP_RELEASE
    } exp_state_t;

    typedef enum logic [2:0] {
        LD_WAIT_RE,
        LD_WAIT_LVAL_LOW,
        LD_DELAY,
        LD_PULSE,
        LD_WAIT_FE
    } load_state_t;

endpackage

// File: rtl/linescanner_phase_timer.sv
// Phase countdown timer. A phase loaded with length L lasts max(L,1) cycles:
// done is high in the last cycle of the phase. The length is captured on
// load, so later changes to the source do not stretch a running phase.
module linescanner_phase_timer
    import linescanner_pkg::*;
#(
    parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
    input  logic                 pixel_clock,
    input  logic                 reset,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] length,
    output logic                 done
);

    logic [CNT_WIDTH-1:0] count_reg;

    // Load remaining-cycles-minus-one, then count down to zero and hold.
    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= (length == '0) ? '0 : length - 1'b1;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign done = (count_reg == '0);

endmodule

// File: rtl/linescanner_capture_controller.sv
// Line-scan sensor controller: exposure timing FSM, load_pulse FSM and the
// registered pixel capture path with line framing and length checking.
// Build option TEST_PATTERN_EN: pixel_data carries a ramp equal to the low
// bits of pixel_index and the data input is ignored; framing is unchanged.
module linescanner_capture_controller
    import linescanner_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int LINE_PIXELS = 1024,
    parameter int CNT_WIDTH   = DEFAULT_CNT_WIDTH,
    parameter int LOAD_DELAY  = 3,
    parameter int LINE_CNT_W  = 16,
    localparam int IDX_W      = (LINE_PIXELS > 1) ? $clog2(LINE_PIXELS) : 1
) (
    input  logic                  pixel_clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  single_shot,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  t_rst_cvc,
    input  logic [CNT_WIDTH-1:0]  t_rst_cds,
    input  logic [CNT_WIDTH-1:0]  t_sample,
    input  logic [CNT_WIDTH-1:0]  t_hold,
    input  logic                  end_adc,
    input  logic                  lval,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  rst_cvc,
    output logic                  rst_cds,
    output logic                  sample,
    output logic                  load_pulse,
    output logic                  pixel_valid,
    output logic [DATA_WIDTH-1:0] pixel_data,
    output logic [IDX_W-1:0]      pixel_index,
    output logic                  line_start,
    output logic                  line_end,
    output logic [LINE_CNT_W-1:0] line_count,
    output logic                  length_error,
    output logic                  busy
);

    localparam int LEN_W = IDX_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(LINE_PIXELS - 1);
    localparam logic [LEN_W-1:0] LINE_TARGET = LEN_W'(LINE_PIXELS);

    // ---------------- exposure FSM ----------------
    exp_state_t           exp_state_reg, exp_state_next;
    logic                 exp_timer_load;
    logic [CNT_WIDTH-1:0] exp_timer_length;
    logic                 exp_timer_done;

    linescanner_phase_timer #(.CNT_WIDTH(CNT_WIDTH)) u_exp_timer (
        .pixel_clock (pixel_clock),
        .reset       (reset),
        .load        (exp_timer_load),
        .length      (exp_timer_length),
        .done        (exp_timer_done)
    );

    // Exposure state register.
    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) exp_state_reg <= EXP_IDLE;
        else       exp_state_reg <= exp_state_next;
    end

    // Exposure next state; the timer is loaded on the edge that enters a timed phase.
    always_comb begin
        exp_state_next   = exp_state_reg;
        exp_timer_load   = 1'b0;
        exp_timer_length = t_rst_cvc;
        rst_cvc          = 1'b1;
        rst_cds          = 1'b1;
        sample           = 1'b0;
        case (exp_state_reg)
            EXP_IDLE: begin
                if (enable && (!single_shot || start)) begin
                    exp_state_next   = EXP_CVC_LOW;
                    exp_timer_load   = 1'b1;
                    exp_timer_length = t_rst_cvc;
                end
            end
            EXP_CVC_LOW: begin
                rst_cvc = 1'b0;
                if (exp_timer_done) begin
                    exp_state_next   = EXP_CDS_LOW;
                    exp_timer_load   = 1'b1;
                    exp_timer_length = t_rst_cds;
                end
            end
            EXP_CDS_LOW: begin
                rst_cvc = 1'b0;
                rst_cds = 1'b0;
                if (exp_timer_done) exp_state_next = EXP_WAIT_ADC;
            end
            EXP_WAIT_ADC: begin
                rst_cvc = 1'b0;
                rst_cds = 1'b0;
                if (end_adc) begin
                    exp_state_next   = EXP_SAMPLE_HI;
                    exp_timer_load   = 1'b1;
                    exp_timer_length = t_sample;
                end
            end
            EXP_SAMPLE_HI: begin
                rst_cvc = 1'b0;
                rst_cds = 1'b0;
                sample  = 1'b1;
                if (exp_timer_done) begin
                    exp_state_next   = EXP_HOLD;
                    exp_timer_load   = 1'b1;
                    exp_timer_length = t_hold;
                end
            end
            EXP_HOLD: begin
                rst_cvc = 1'b0;
                rst_cds = 1'b0;
                if (exp_timer_done) exp_state_next = EXP_RELEASE;
            end
            EXP_RELEASE: exp_state_next = EXP_IDLE;
            default:     exp_state_next = EXP_IDLE;
        endcase
    end

    assign busy = (exp_state_reg != EXP_IDLE);

    // ---------------- load FSM ----------------
    load_state_t          load_state_reg, load_state_next;
    logic                 end_adc_reg;
    logic                 load_timer_load;
    logic                 load_timer_done;

    linescanner_phase_timer #(.CNT_WIDTH(CNT_WIDTH)) u_load_timer (
        .pixel_clock (pixel_clock),
        .reset       (reset),
        .load        (load_timer_load),
        .length      (CNT_WIDTH'(LOAD_DELAY - 1)),
        .done        (load_timer_done)
    );

    // Load state register and end_adc history for rising-edge detection.
    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            load_state_reg <= LD_WAIT_RE;
            end_adc_reg    <= 1'b0;
        end else begin
            load_state_reg <= load_state_next;
            end_adc_reg    <= end_adc;
        end
    end

    // Load next state. The cycle that first sees lval low counts as the first
    // of the LOAD_DELAY cycles, so DELAY itself spans LOAD_DELAY-1 cycles.
    always_comb begin
        load_state_next = load_state_reg;
        load_timer_load = 1'b0;
        load_pulse      = 1'b0;
        case (load_state_reg)
            LD_WAIT_RE: begin
                if (end_adc && !end_adc_reg) load_state_next = LD_WAIT_LVAL_LOW;
            end
            LD_WAIT_LVAL_LOW: begin
                if (!lval) begin
                    if (LOAD_DELAY <= 1) begin
                        load_state_next = LD_PULSE;
                    end else begin
                        load_state_next = LD_DELAY;
                        load_timer_load = 1'b1;
                    end
                end
            end
            LD_DELAY:   if (load_timer_done) load_state_next = LD_PULSE;
            LD_PULSE: begin
                load_pulse      = 1'b1;
                load_state_next = LD_WAIT_FE;
            end
            LD_WAIT_FE: if (!end_adc) load_state_next = LD_WAIT_RE;
            default:    load_state_next = LD_WAIT_RE;
        endcase
    end

    // ---------------- capture pipeline ----------------
    logic                  lval_reg;
    logic                  line_start_reg;
    logic                  line_end_reg;
    logic [IDX_W-1:0]      index_reg;
    logic [LEN_W-1:0]      length_reg;
    logic [LINE_CNT_W-1:0] line_count_reg;
    logic                  length_error_reg;

    // Framing, pixel index and line-length bookkeeping, one cycle behind lval.
    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            lval_reg         <= 1'b0;
            line_start_reg   <= 1'b0;
            line_end_reg     <= 1'b0;
            index_reg        <= '0;
            length_reg       <= '0;
            line_count_reg   <= '0;
            length_error_reg <= 1'b0;
        end else begin
            lval_reg       <= lval;
            line_start_reg <= lval && !lval_reg;
            line_end_reg   <= !lval && lval_reg;
            if (lval && !lval_reg) begin
                index_reg  <= '0;
                length_reg <= LEN_W'(1);
            end else if (lval) begin
                if (index_reg != LAST_IDX) index_reg <= index_reg + 1'b1;
                if (length_reg != '1)      length_reg <= length_reg + 1'b1;
            end
            if (!lval && lval_reg) begin
                line_count_reg <= line_count_reg + 1'b1;
                if (length_reg != LINE_TARGET) length_error_reg <= 1'b1;
            end
        end
    end

`ifdef TEST_PATTERN_EN
    assign pixel_data = DATA_WIDTH'(index_reg);
`else
    logic [DATA_WIDTH-1:0] data_reg;

    // Pixel data pipeline register, aligned with pixel_valid.
    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) data_reg <= '0;
        else       data_reg <= data;
    end

    assign pixel_data = data_reg;
`endif

    assign pixel_valid  = lval_reg;
    assign pixel_index  = index_reg;
    assign line_start   = line_start_reg;
    assign line_end     = line_end_reg;
    assign line_count   = line_count_reg;
    assign length_error = length_error_reg;

endmodule

// File: tb/tb_linescanner_capture_controller.sv
// Directed testbench for linescanner_capture_controller (LINE_PIXELS=16).
// Expected values are hand-derived; pixel_data expectation follows the
// TEST_PATTERN_EN build option.
module tb_linescanner_capture_controller;

    logic       pixel_clock;
    logic       reset;
    logic       enable;
    logic       single_shot;
    logic       start;
    logic [7:0] t_rst_cvc;
    logic [7:0] t_rst_cds;
    logic [7:0] t_sample;
    logic [7:0] t_hold;
    logic       end_adc;
    logic       lval;
    logic [7:0] data;
    logic       rst_cvc;
    logic       rst_cds;
    logic       sample;
    logic       load_pulse;
    logic       pixel_valid;
    logic [7:0] pixel_data;
    logic [3:0] pixel_index;
    logic       line_start;
    logic       line_end;
    logic [15:0] line_count;
    logic       length_error;
    logic       busy;

    int checks = 0;
    int errors = 0;

    linescanner_capture_controller #(
        .DATA_WIDTH  (8),
        .LINE_PIXELS (16),
        .CNT_WIDTH   (8),
        .LOAD_DELAY  (3),
        .LINE_CNT_W  (16)
    ) dut (
        .pixel_clock  (pixel_clock),
        .reset        (reset),
        .enable       (enable),
        .single_shot  (single_shot),
        .start        (start),
        .t_rst_cvc    (t_rst_cvc),
        .t_rst_cds    (t_rst_cds),
        .t_sample     (t_sample),
        .t_hold       (t_hold),
        .end_adc      (end_adc),
        .lval         (lval),
        .data         (data),
        .rst_cvc      (rst_cvc),
        .rst_cds      (rst_cds),
        .sample       (sample),
        .load_pulse   (load_pulse),
        .pixel_valid  (pixel_valid),
        .pixel_data   (pixel_data),
        .pixel_index  (pixel_index),
        .line_start   (line_start),
        .line_end     (line_end),
        .line_count   (line_count),
        .length_error (length_error),
        .busy         (busy)
    );

    initial pixel_clock = 1'b0;
    always #5 pixel_clock = ~pixel_clock;

    // One clock edge, then settle before inputs change or outputs are read.
    task automatic tick();
        @(posedge pixel_clock);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end else begin
            $display("ok   %s = 0x%0h", tag, observed);
        end
    endtask

    function automatic logic get_sig(input int sel);
        case (sel)
            0:       return rst_cvc;
            1:       return rst_cds;
            2:       return sample;
            3:       return busy;
            default: return load_pulse;
        endcase
    endfunction

    // Count edges until the selected output reaches val; an expired bound is a failure.
    task automatic wait_sig(input string tag, input int sel, input logic val,
                            input int limit, output int n);
        n = 0;
        while (get_sig(sel) !== val && n < limit) begin
            tick();
            n++;
        end
        if (get_sig(sel) !== val) check_eq({tag, "_timeout"}, 32'(get_sig(sel)), 32'(val));
    endtask

    // Drive an lval window of n pixels (data = base+i) and check each output pixel.
    task automatic send_line(input string tag, input int n, input logic [7:0] base);
        logic [7:0] exp_data;
        int         exp_idx;
        for (int i = 0; i < n; i++) begin
            lval = 1'b1;
            data = 8'(base + i);
            tick();
            exp_idx = (i > 15) ? 15 : i;
`ifdef TEST_PATTERN_EN
            exp_data = 8'(exp_idx);
`else
            exp_data = 8'(base + i);
`endif
            check_eq($sformatf("%s_valid[%0d]", tag, i), 32'(pixel_valid), 32'd1);
            check_eq($sformatf("%s_index[%0d]", tag, i), 32'(pixel_index), 32'(exp_idx));
            check_eq($sformatf("%s_data[%0d]", tag, i), 32'(pixel_data), 32'(exp_data));
            check_eq($sformatf("%s_start[%0d]", tag, i), 32'(line_start), (i == 0) ? 32'd1 : 32'd0);
        end
        lval = 1'b0;
        data = 8'h00;
        tick();
        check_eq({tag, "_line_end"}, 32'(line_end), 32'd1);
        check_eq({tag, "_valid_off"}, 32'(pixel_valid), 32'd0);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int pulses;
        reset = 1'b1;
        enable = 1'b0;
        single_shot = 1'b0;
        start = 1'b0;
        t_rst_cvc = 8'd5;
        t_rst_cds = 8'd3;
        t_sample = 8'd4;
        t_hold = 8'd2;
        end_adc = 1'b0;
        lval = 1'b0;
        data = 8'h00;
        repeat (3) tick();

        // Reset values
        check_eq("rst_rst_cvc", 32'(rst_cvc), 32'd1);
        check_eq("rst_rst_cds", 32'(rst_cds), 32'd1);
        check_eq("rst_sample", 32'(sample), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_line_count", 32'(line_count), 32'd0);
        check_eq("rst_pixel_valid", 32'(pixel_valid), 32'd0);
        reset = 1'b0;
        tick();

        // 1: free-running exposure timing
        enable = 1'b1;
        wait_sig("t1_cvc_low", 0, 1'b0, 10, n);
        check_eq("t1_cvc_low_latency", 32'(n), 32'd1);
        wait_sig("t1_cds_low", 1, 1'b0, 20, n);
        check_eq("t1_cvc_to_cds", 32'(n), 32'd5);
        repeat (10) tick();
        check_eq("t1_wait_adc_no_sample", 32'(sample), 32'd0);
        end_adc = 1'b1;
        wait_sig("t1_sample_hi", 2, 1'b1, 10, n);
        check_eq("t1_sample_latency", 32'(n), 32'd1);
        end_adc = 1'b0;
        wait_sig("t1_sample_lo", 2, 1'b0, 20, n);
        check_eq("t1_sample_width", 32'(n), 32'd4);
        wait_sig("t1_release", 0, 1'b1, 20, n);
        check_eq("t1_hold_len", 32'(n), 32'd2);
        check_eq("t1_release_cds", 32'(rst_cds), 32'd1);
        check_eq("t1_release_busy", 32'(busy), 32'd1);
        tick();
        check_eq("t1_idle_busy", 32'(busy), 32'd0);
        tick();
        check_eq("t1_freerun_restart", 32'(rst_cvc), 32'd0);
        enable = 1'b0;
        wait_sig("t1b_cds_low", 1, 1'b0, 20, n);
        end_adc = 1'b1;
        wait_sig("t1b_sample_hi", 2, 1'b1, 20, n);
        check_eq("t1b_cds_to_sample", 32'(n), 32'd4);
        end_adc = 1'b0;
        wait_sig("t1b_release", 0, 1'b1, 30, n);
        repeat (6) tick();
        check_eq("t1b_no_restart_busy", 32'(busy), 32'd0);
        check_eq("t1b_no_restart_cvc", 32'(rst_cvc), 32'd1);

        // 2: single-shot, extra starts while busy are ignored
        single_shot = 1'b1;
        enable = 1'b1;
        repeat (3) tick();
        check_eq("t2_idle_no_start", 32'(busy), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("t2_started", 32'(busy), 32'd1);
        wait_sig("t2_cds_low", 1, 1'b0, 20, n);
        start = 1'b1;
        tick();
        start = 1'b0;
        end_adc = 1'b1;
        wait_sig("t2_sample_hi", 2, 1'b1, 20, n);
        end_adc = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_sig("t2_release", 0, 1'b1, 30, n);
        check_eq("t2_release_busy", 32'(busy), 32'd1);
        tick();
        check_eq("t2_busy_drop", 32'(busy), 32'd0);
        repeat (20) tick();
        check_eq("t2_single_cycle", 32'(busy), 32'd0);
        enable = 1'b0;
        single_shot = 1'b0;
        repeat (3) tick();

        // 3: good 16-pixel line
        send_line("t3", 16, 8'hA0);
        check_eq("t3_line_count", 32'(line_count), 32'd1);
        check_eq("t3_no_error", 32'(length_error), 32'd0);
        tick();
        check_eq("t3_line_end_pulse", 32'(line_end), 32'd0);

        // 4: short line sets sticky error; survives a good line
        send_line("t4s", 15, 8'h10);
        check_eq("t4_line_count", 32'(line_count), 32'd2);
        check_eq("t4_error_set", 32'(length_error), 32'd1);
        tick();
        send_line("t4g", 16, 8'h40);
        check_eq("t4_line_count_good", 32'(line_count), 32'd3);
        check_eq("t4_error_sticky", 32'(length_error), 32'd1);
        tick();

        // 5: end_adc rises during lval; load_pulse 3 cycles after lval low, width 1
        pulses = 0;
        lval = 1'b1;
        data = 8'h77;
        end_adc = 1'b1;
        tick();
        if (load_pulse) pulses++;
        repeat (6) begin
            tick();
            if (load_pulse) pulses++;
        end
        check_eq("t5_no_pulse_in_lval", 32'(pulses), 32'd0);
        lval = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check_eq($sformatf("t5_load_pulse[%0d]", k), 32'(load_pulse), (k == 3) ? 32'd1 : 32'd0);
        end
        check_eq("t5_line_count", 32'(line_count), 32'd4);
        end_adc = 1'b0;
        repeat (3) tick();

        // 6: async reset mid-line and in SAMPLE_HI
        enable = 1'b1;
        wait_sig("t6_cds_low", 1, 1'b0, 30, n);
        end_adc = 1'b1;
        wait_sig("t6_sample_hi", 2, 1'b1, 20, n);
        end_adc = 1'b0;
        lval = 1'b1;
        data = 8'h55;
        tick();
        tick();
        check_eq("t6_pre_sample", 32'(sample), 32'd1);
        check_eq("t6_pre_valid", 32'(pixel_valid), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check_eq("t6_rst_cvc", 32'(rst_cvc), 32'd1);
        check_eq("t6_rst_cds", 32'(rst_cds), 32'd1);
        check_eq("t6_sample", 32'(sample), 32'd0);
        check_eq("t6_load_pulse", 32'(load_pulse), 32'd0);
        check_eq("t6_pixel_valid", 32'(pixel_valid), 32'd0);
        check_eq("t6_pixel_data", 32'(pixel_data), 32'd0);
        check_eq("t6_pixel_index", 32'(pixel_index), 32'd0);
        check_eq("t6_line_start", 32'(line_start), 32'd0);
        check_eq("t6_line_end", 32'(line_end), 32'd0);
        check_eq("t6_line_count", 32'(line_count), 32'd0);
        check_eq("t6_length_error", 32'(length_error), 32'd0);
        check_eq("t6_busy", 32'(busy), 32'd0);
        enable = 1'b0;
        lval = 1'b0;
        tick();
        reset = 1'b0;
        repeat (2) tick();
        check_eq("t6_after_busy", 32'(busy), 32'd0);
        check_eq("t6_after_line_count", 32'(line_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
